// File: rtl/uart_sys_pkg.sv
// Shared opcodes, operand addresses and FSM encodings for the UART command controller.
package uart_sys_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
      OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1
   } state_t;

   typedef enum logic [1:0] {
      TXS_IDLE, TXS_REQ, TXS_DRAIN
   } tx_state_t;

   function automatic logic is_rx_state(input state_t s);
      return s inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN};
   endfunction

endpackage

// File: rtl/uart_tx_sender.sv
// Hands one byte to the UART TX: request while idle, hold until busy is seen, then wait for idle.
// tx_valid rises one cycle after send with tx_busy low; byte_done pulses when the transmitter frees up.
module uart_tx_sender
   import uart_sys_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [DATA_W-1:0] data,
   input  logic              tx_busy,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              byte_done
);

   tx_state_t st_q, st_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q    <= TXS_IDLE;
         tx_data <= '0;
      end else begin
         st_q <= st_nxt;
         if (st_q == TXS_IDLE && st_nxt == TXS_REQ)
            tx_data <= data;
      end
   end

   always_comb begin
      st_nxt = st_q;
      case (st_q)
         TXS_IDLE:  if (send && !tx_busy) st_nxt = TXS_REQ;
         TXS_REQ:   if (tx_busy)          st_nxt = TXS_DRAIN;
         TXS_DRAIN: if (!tx_busy)         st_nxt = TXS_IDLE;
         default:                         st_nxt = TXS_IDLE;
      endcase
   end

   always_comb begin
      tx_valid  = (st_q == TXS_REQ);
      byte_done = (st_q == TXS_DRAIN) && !tx_busy;
   end

endmodule

// File: rtl/uart_sys_ctrl.sv
// Decodes UART command frames into register-file / ALU accesses and streams responses back out.
// Optional build macro CMD_TIMEOUT_EN drops partial frames after TIMEOUT_CYC idle cycles.
module uart_sys_ctrl
   import uart_sys_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int ALU_W       = 16,
   parameter int FUN_W       = 4,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_par_err,
   input  logic              rx_stop_err,
   input  logic              tx_busy,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_wr_en,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              rf_rd_en,
   input  logic [DATA_W-1:0] rf_rd_data,
   input  logic              rf_rd_valid,
   output logic              alu_en,
   output logic [FUN_W-1:0]  alu_fun,
   input  logic [ALU_W-1:0]  alu_out,
   input  logic              alu_out_valid
);

   if (ALU_W != 2 * DATA_W || TIMEOUT_CYC < 1) begin : g_cfg_chk
      $error("uart_sys_ctrl: ALU_W must be 2*DATA_W and TIMEOUT_CYC positive");
   end

   state_t            state_q, state_nxt;
   logic              acc, err, tmo, byte_done;
   logic [ADDR_W-1:0] addr_q, wr_addr_nxt;
   logic [ALU_W-1:0]  resp_q;
   logic              two_q;
   logic              wr_nxt, rd_nxt, alu_nxt;

   assign acc = rx_valid && !rx_par_err && !rx_stop_err;
   assign err = rx_valid && (rx_par_err || rx_stop_err);

`ifdef CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (!rst || acc || !is_rx_state(state_q))
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo = is_rx_state(state_q) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:
            if (acc) begin
               case (rx_data)
                  CMD_RF_WR:   state_nxt = WR_ADDR;
                  CMD_RF_RD:   state_nxt = RD_ADDR;
                  CMD_ALU_OP:  state_nxt = OP_A;
                  CMD_ALU_NOP: state_nxt = ALU_FUN;
                  default:     state_nxt = IDLE;
               endcase
            end
         WR_ADDR:  if (acc) state_nxt = WR_DATA;  else if (err) state_nxt = IDLE;
         WR_DATA:  if (acc || err) state_nxt = IDLE;
         RD_ADDR:  if (acc) state_nxt = RD_WAIT;  else if (err) state_nxt = IDLE;
         OP_A:     if (acc) state_nxt = OP_B;     else if (err) state_nxt = IDLE;
         OP_B:     if (acc) state_nxt = ALU_FUN;  else if (err) state_nxt = IDLE;
         ALU_FUN:  if (acc) state_nxt = ALU_WAIT; else if (err) state_nxt = IDLE;
         RD_WAIT:  if (rf_rd_valid)   state_nxt = TX_B0;
         ALU_WAIT: if (alu_out_valid) state_nxt = TX_B0;
         TX_B0:    if (byte_done) state_nxt = two_q ? TX_B1 : IDLE;
         TX_B1:    if (byte_done) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (tmo) state_nxt = IDLE;
   end

   // A timed-out frame must not leave a side effect even if a byte lands on that cycle.
   always_comb begin
      wr_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      alu_nxt     = 1'b0;
      wr_addr_nxt = addr_q;
      if (acc && !tmo) begin
         case (state_q)
            WR_DATA: wr_nxt = 1'b1;
            OP_A: begin wr_nxt = 1'b1; wr_addr_nxt = ADDR_W'(OPA_ADDR); end
            OP_B: begin wr_nxt = 1'b1; wr_addr_nxt = ADDR_W'(OPB_ADDR); end
            RD_ADDR: rd_nxt  = 1'b1;
            ALU_FUN: alu_nxt = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         alu_en     <= 1'b0;
         rf_addr    <= '0;
         rf_wr_data <= '0;
         alu_fun    <= '0;
         addr_q     <= '0;
         resp_q     <= '0;
         two_q      <= 1'b0;
      end else begin
         rf_wr_en <= wr_nxt;
         rf_rd_en <= rd_nxt;
         alu_en   <= alu_nxt;
         if (wr_nxt) begin
            rf_addr    <= wr_addr_nxt;
            rf_wr_data <= rx_data;
         end
         if (rd_nxt)  rf_addr <= rx_data[ADDR_W-1:0];
         if (alu_nxt) alu_fun <= rx_data[FUN_W-1:0];
         if (state_q == WR_ADDR && acc) addr_q <= rx_data[ADDR_W-1:0];
         if (state_q == RD_WAIT && rf_rd_valid) begin
            resp_q <= {{(ALU_W-DATA_W){1'b0}}, rf_rd_data};
            two_q  <= 1'b0;
         end
         if (state_q == ALU_WAIT && alu_out_valid) begin
            resp_q <= alu_out;
            two_q  <= 1'b1;
         end
      end
   end

   uart_tx_sender #(.DATA_W(DATA_W)) u_tx (
      .clk       (clk),
      .rst       (rst),
      .send      (state_q == TX_B0 || state_q == TX_B1),
      .data      ((state_q == TX_B1) ? resp_q[DATA_W +: DATA_W] : resp_q[DATA_W-1:0]),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .byte_done (byte_done)
   );

endmodule
